// File: rtl/lcd_frame_writer_if.sv
// ROM-handshake and LCD write-bus signals of the frame writer.
// The slave modport belongs to the writer; the master modport belongs to the surrounding logic.
interface lcd_frame_writer_if;
    logic       start_i;
    logic [8:0] d_i;
    logic [5:0] length_i;
    logic       sync_o;
    logic       en_o;
    logic       lcd_cs_n_o;
    logic       lcd_rs_o;
    logic       lcd_wr_n_o;
    logic [7:0] lcd_d_o;
    logic       busy_o;
    logic       done_o;

    modport slave (
        input  start_i, d_i, length_i,
        output sync_o, en_o, lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o, busy_o, done_o
    );

    modport master (
        output start_i, d_i, length_i,
        input  sync_o, en_o, lcd_cs_n_o, lcd_rs_o, lcd_wr_n_o, lcd_d_o, busy_o, done_o
    );
endinterface

// File: rtl/lcd_frame_writer.sv
// Pulls 9-bit {byte, rs} words from the character ROM and writes them to an 8080-style
// LCD bus with programmable setup / strobe / hold timing. Every output is a flop.
module lcd_frame_writer #(
    parameter int unsigned SETUP_CYC = 2,
    parameter int unsigned PULSE_CYC = 4,
    parameter int unsigned HOLD_CYC  = 2
) (
    input logic          clk,
    input logic          rst_n,
    lcd_frame_writer_if.slave bus
);
    localparam int unsigned TMAX = (SETUP_CYC > PULSE_CYC)
                                 ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                 : ((PULSE_CYC > HOLD_CYC) ? PULSE_CYC : HOLD_CYC);
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

    localparam logic [TW-1:0] SETUP_LD = TW'(SETUP_CYC - 1);
    localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYC - 1);
    localparam logic [TW-1:0] HOLD_LD  = TW'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_SYNC, S_LOAD, S_SETUP, S_STROBE, S_HOLD, S_NEXT, S_DONE
    } state_t;

    state_t        r_state;
    logic [TW-1:0] r_timer;
    logic [5:0]    r_word_cnt;
    logic [5:0]    r_len;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_timer        <= '0;
            r_word_cnt     <= '0;
            r_len          <= '0;
            bus.sync_o     <= 1'b0;
            bus.en_o       <= 1'b1;
            bus.lcd_cs_n_o <= 1'b1;
            bus.lcd_wr_n_o <= 1'b1;
            bus.lcd_rs_o   <= 1'b0;
            bus.lcd_d_o    <= '0;
            bus.busy_o     <= 1'b0;
            bus.done_o     <= 1'b0;
        end else begin
            // Pulse outputs are raised on the edge entering their state so they are high exactly for that state.
            bus.sync_o <= 1'b0;
            bus.en_o   <= 1'b1;
            bus.done_o <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_len      <= bus.length_i;
                        bus.sync_o <= 1'b1;
                        bus.busy_o <= 1'b1;
                        r_state    <= S_SYNC;
                    end
                end
                S_SYNC: begin
                    r_word_cnt <= '0;
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    bus.lcd_d_o    <= bus.d_i[8:1];
                    bus.lcd_rs_o   <= bus.d_i[0];
                    bus.lcd_cs_n_o <= 1'b0;
                    r_timer        <= SETUP_LD;
                    r_state        <= S_SETUP;
                end
                S_SETUP: begin
                    if (r_timer == '0) begin
                        bus.lcd_wr_n_o <= 1'b0;
                        r_timer        <= PULSE_LD;
                        r_state        <= S_STROBE;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_STROBE: begin
                    if (r_timer == '0) begin
                        bus.lcd_wr_n_o <= 1'b1;
                        r_timer        <= HOLD_LD;
                        r_state        <= S_HOLD;
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_HOLD: begin
                    if (r_timer == '0) begin
                        if (r_word_cnt == r_len) begin
                            bus.lcd_cs_n_o <= 1'b1;
                            bus.done_o     <= 1'b1;
                            r_state        <= S_DONE;
                        end else begin
                            bus.en_o <= 1'b0;
                            r_state  <= S_NEXT;
                        end
                    end else begin
                        r_timer <= r_timer - TW'(1);
                    end
                end
                S_NEXT: begin
                    r_word_cnt <= r_word_cnt + 6'd1;
                    r_state    <= S_LOAD;
                end
                S_DONE: begin
                    bus.busy_o <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_lcd_frame_writer.sv
// Bench for lcd_frame_writer: a ROM model feeds two instances (default timing and 1/1/3 timing);
// every cycle is traced and compared against a timeline model derived from the frame rules.
module tb_lcd_frame_writer;
  localparam int N = 16384;
  // snapshot layout: {sync, en, cs_n, rs, wr_n, d[7:0], busy, done}
  localparam logic [14:0] RST_SNAP  = 15'b011_0_1_00000000_00;
  localparam logic [14:0] MASK_NO_D = 15'b111_0_1_00000000_11;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  lcd_frame_writer_if bus_a ();
  lcd_frame_writer_if bus_b ();

  lcd_frame_writer u_a (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_a.slave)
  );

  lcd_frame_writer #(.SETUP_CYC(1), .PULSE_CYC(1), .HOLD_CYC(3)) u_b (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_b.slave)
  );

  logic [8:0]  rom [2][64];
  logic [5:0]  rom_idx [2] = '{6'd0, 6'd0};
  logic [14:0] snap [2];
  logic [14:0] trace [2][N];
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;

  assign bus_a.d_i = rom[0][rom_idx[0]];
  assign bus_b.d_i = rom[1][rom_idx[1]];
  assign snap[0] = {bus_a.sync_o, bus_a.en_o, bus_a.lcd_cs_n_o, bus_a.lcd_rs_o, bus_a.lcd_wr_n_o,
                    bus_a.lcd_d_o, bus_a.busy_o, bus_a.done_o};
  assign snap[1] = {bus_b.sync_o, bus_b.en_o, bus_b.lcd_cs_n_o, bus_b.lcd_rs_o, bus_b.lcd_wr_n_o,
                    bus_b.lcd_d_o, bus_b.busy_o, bus_b.done_o};

  // Character ROM: sync clears the index, an active-low en advances it.
  always @(posedge clk) begin
    if (bus_a.sync_o) rom_idx[0] <= 6'd0;
    else if (!bus_a.en_o) rom_idx[0] <= rom_idx[0] + 6'd1;
    if (bus_b.sync_o) rom_idx[1] <= 6'd0;
    else if (!bus_b.en_o) rom_idx[1] <= rom_idx[1] + 6'd1;
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    trace[0][cyc % N] <= snap[0];
    trace[1][cyc % N] <= snap[1];
  end

  // Expected outputs at cycle c of a frame whose sync_o is high in cycle s.
  function automatic logic [14:0] model_snap(int inst, int c, int s, int len, int su, int pw, int ho);
    int p, last, rel, k;
    logic [8:0] w;
    logic sync, en, cs_n, wr_n, busy, done;
    p    = su + pw + ho + 2;
    last = s + 2 + len * p + su + pw + ho;
    sync = (c == s);
    done = (c == last);
    busy = (c >= s) && (c <= last);
    cs_n = !((c >= s + 2) && (c < last));
    en   = 1'b1;
    wr_n = 1'b1;
    w    = 9'h000;
    if (c >= s + 2) begin
      rel = c - s - 2;
      k   = rel / p;
      if (k > len) k = len;
      w = rom[inst][k];
      if ((rel - k * p) >= su && (rel - k * p) < su + pw) wr_n = 1'b0;
    end
    if (c > s && ((c - s) % p) == 0 && ((c - s) / p) >= 1 && ((c - s) / p) <= len) en = 1'b0;
    return {sync, en, cs_n, w[0], wr_n, w[8:1], busy, done};
  endfunction

  function automatic int frame_last(int s, int len, int su, int pw, int ho);
    return s + 2 + len * (su + pw + ho + 2) + su + pw + ho;
  endfunction

  task automatic fill_rom(int inst);
    for (int unsigned k = 0; k < 64; k++) rom[inst][k] = 9'($urandom);
    rom[inst][0] = 9'h1F8;
  endtask

  task automatic wait_cyc(int target);
    while (cyc < target) @(negedge clk);
    #1;
  endtask

  task automatic start_frame(int inst, logic [5:0] len, output int s);
    @(negedge clk);
    if (inst == 0) begin bus_a.length_i = len; bus_a.start_i = 1'b1; end
    else begin bus_b.length_i = len; bus_b.start_i = 1'b1; end
    s = cyc + 1;
    @(negedge clk);
    bus_a.start_i = 1'b0;
    bus_b.start_i = 1'b0;
  endtask

  task automatic test_reset();
    int rel;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    rel = cyc;
    wait_cyc(rel + 51);
    for (int unsigned i = 0; i < 2; i++) begin
      for (int c = 1; c <= rel + 50; c++) begin
        checks++;
        if (trace[i][c % N] !== RST_SNAP) begin
          failures++;
          $display("FAIL reset_idle inst=%0d cyc=%0d got=%h exp=%h", i, c, trace[i][c % N], RST_SNAP);
        end
      end
    end
  endtask

  task automatic test_full_frame();
    int s, last, nf, nlow, ne, nd, first;
    logic [14:0] e, a, pa;
    logic [8:0] w0;
    fill_rom(0);
    start_frame(0, 6'd31, s);
    last = frame_last(s, 31, 2, 4, 2);
    wait_cyc(last + 2);
    for (int c = s; c <= last + 1; c++) begin
      e = model_snap(0, c, s, 31, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL full_frame cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
    nf = 0; nlow = 0; ne = 0; nd = 0; first = -1;
    for (int c = s; c <= last + 1; c++) begin
      a  = trace[0][c % N];
      pa = trace[0][(c - 1) % N];
      if (!a[10] && pa[10]) begin nf++; if (first < 0) first = c - s; end
      if (!a[10]) nlow++;
      if (!a[13]) ne++;
      if (a[0]) nd++;
    end
    a  = trace[0][(s + 2) % N];
    w0 = {a[9:2], a[11]};
    checks++; if (nf != 32)    begin failures++; $display("FAIL full_strobes got=%0d exp=32", nf); end
    checks++; if (nlow != 128) begin failures++; $display("FAIL full_low_cycles got=%0d exp=128", nlow); end
    checks++; if (ne != 31)    begin failures++; $display("FAIL full_en_pulses got=%0d exp=31", ne); end
    checks++; if (nd != 1)     begin failures++; $display("FAIL full_done_pulses got=%0d exp=1", nd); end
    checks++; if (first != 4)  begin failures++; $display("FAIL full_first_fall got=E%0d exp=E4", first); end
    checks++; if (w0 !== 9'h1F8) begin failures++; $display("FAIL full_word0 got=%h exp=1f8", w0); end
  endtask

  task automatic test_length_zero();
    int s, last, ne;
    logic [14:0] e, a;
    fill_rom(0);
    start_frame(0, 6'd0, s);
    last = frame_last(s, 0, 2, 4, 2);
    wait_cyc(last + 2);
    ne = 0;
    for (int c = s; c <= last + 1; c++) begin
      e = model_snap(0, c, s, 0, 2, 4, 2);
      a = trace[0][c % N];
      if (!a[13]) ne++;
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL len0 cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
    checks++; if (ne != 0) begin failures++; $display("FAIL len0_en_pulses got=%0d exp=0", ne); end
    a = trace[0][(s + 10) % N];
    checks++; if (a[0] !== 1'b1) begin failures++; $display("FAIL len0_done_at_E10 got=%b exp=1", a[0]); end
  endtask

  task automatic test_timing();
    int s, last, len, prev_fall, nf;
    logic [14:0] e, a, pa;
    fill_rom(1);
    len = $urandom_range(3, 8);
    start_frame(1, 6'(len), s);
    last = frame_last(s, len, 1, 1, 3);
    wait_cyc(last + 2);
    prev_fall = -1; nf = 0;
    for (int c = s; c <= last + 1; c++) begin
      e  = model_snap(1, c, s, len, 1, 1, 3);
      a  = trace[1][c % N];
      pa = trace[1][(c - 1) % N];
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL timing cyc=%0d got=%h exp=%h", c - s, a, e);
      end
      if (!a[10] && pa[10]) begin
        nf++;
        if (prev_fall >= 0) begin
          checks++;
          if (c - prev_fall != 7) begin
            failures++;
            $display("FAIL timing_period got=%0d exp=7", c - prev_fall);
          end
        end
        prev_fall = c;
      end
    end
    checks++;
    if (nf != len + 1) begin
      failures++;
      $display("FAIL timing_strobes got=%0d exp=%0d", nf, len + 1);
    end
  endtask

  task automatic test_max_length();
    int s, last, ne;
    logic [14:0] e, a;
    fill_rom(0);
    start_frame(0, 6'd63, s);
    last = frame_last(s, 63, 2, 4, 2);
    wait_cyc(last + 2);
    ne = 0;
    for (int c = s; c <= last + 1; c++) begin
      e = model_snap(0, c, s, 63, 2, 4, 2);
      a = trace[0][c % N];
      if (!a[13]) ne++;
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL max_len cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
    checks++; if (ne != 63) begin failures++; $display("FAIL max_len_en_pulses got=%0d exp=63", ne); end
  endtask

  task automatic test_length_latched();
    int s, last, len;
    logic [14:0] e, a;
    fill_rom(0);
    len = $urandom_range(2, 6);
    start_frame(0, 6'(len), s);
    bus_a.length_i = 6'(len + 20);
    last = frame_last(s, len, 2, 4, 2);
    wait_cyc(last + 2);
    for (int c = s; c <= last + 1; c++) begin
      e = model_snap(0, c, s, len, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL len_latched cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
  endtask

  task automatic test_start_held();
    int s, s2, last, last2;
    logic [14:0] e, a;
    fill_rom(0);
    @(negedge clk);
    bus_a.length_i = 6'd2;
    bus_a.start_i  = 1'b1;
    s    = cyc + 1;
    last = frame_last(s, 2, 2, 4, 2);
    s2   = last + 2;
    wait_cyc(s2);
    bus_a.start_i = 1'b0;
    for (int c = s; c <= last + 1; c++) begin
      e = model_snap(0, c, s, 2, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL start_held cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
    last2 = frame_last(s2, 2, 2, 4, 2);
    wait_cyc(last2 + 2);
    for (int c = s2; c <= last2 + 1; c++) begin
      e = model_snap(0, c, s2, 2, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s2 + 2) ? MASK_NO_D : '1)) !== (e & ((c < s2 + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL start_held_second cyc=%0d got=%h exp=%h", c - s2, a, e);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, fall5, r, s2, last2;
    logic [14:0] e, a;
    fill_rom(0);
    start_frame(0, 6'd10, s);
    fall5 = s + 2 + 5 * 10 + 2;
    r     = fall5 + 2;
    wait_cyc(fall5 + 1);
    rst_n = 1'b0;
    wait_cyc(r);
    rst_n = 1'b1;
    for (int c = s; c < r; c++) begin
      e = model_snap(0, c, s, 10, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s + 2) ? MASK_NO_D : '1)) !== (e & ((c < s + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL mid_reset_pre cyc=%0d got=%h exp=%h", c - s, a, e);
      end
    end
    a = trace[0][r % N];
    checks++;
    if (a !== RST_SNAP) begin
      failures++;
      $display("FAIL mid_reset_state got=%h exp=%h", a, RST_SNAP);
    end
    start_frame(0, 6'd3, s2);
    last2 = frame_last(s2, 3, 2, 4, 2);
    wait_cyc(last2 + 2);
    for (int c = s2; c <= last2 + 1; c++) begin
      e = model_snap(0, c, s2, 3, 2, 4, 2);
      a = trace[0][c % N];
      checks++;
      if ((a & ((c < s2 + 2) ? MASK_NO_D : '1)) !== (e & ((c < s2 + 2) ? MASK_NO_D : '1))) begin
        failures++;
        $display("FAIL mid_reset_restart cyc=%0d got=%h exp=%h", c - s2, a, e);
      end
    end
  endtask

  initial begin
    bus_a.start_i  = 1'b0;
    bus_a.length_i = 6'd0;
    bus_b.start_i  = 1'b0;
    bus_b.length_i = 6'd0;
    fill_rom(0);
    fill_rom(1);
    test_reset();
    test_full_frame();
    test_length_zero();
    test_timing();
    test_max_length();
    test_length_latched();
    test_start_held();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
